// File: rtl/mfa_symbol_streamer.sv
// mfa_symbol_streamer: FIFO-buffered serializer turning packed words into 2-bit symbols for the MFA core.
// Define SYM_COUNT_EN to add the saturating per-sequence sym_count output.
module mfa_symbol_streamer #(
  parameter int WORD_LEN = 32,
  parameter int NSYM_LEN = 5,
  parameter int FIFO_AW  = 2,
  parameter int CNT_LEN  = 12
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WORD_LEN-1:0] in_data,
  input  logic [NSYM_LEN-1:0] in_nsym,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                hold,
  output logic [1:0]          symbol,
  output logic                sym_valid,
  output logic                BC_mode,
  output logic                seq_done
`ifdef SYM_COUNT_EN
  ,
  output logic [CNT_LEN-1:0]  sym_count
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam int NSYM = WORD_LEN / 2;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int EW = WORD_LEN + 1 + NSYM_LEN;
  localparam logic [FIFO_AW:0] FULL_OCC = (FIFO_AW + 1)'(DEPTH);
  localparam logic [NSYM_LEN-1:0] FULL_REM = NSYM_LEN'(NSYM);

  if ((WORD_LEN % 2) != 0 || (2 ** (NSYM_LEN - 1)) != NSYM || CNT_LEN < 1) begin : g_bad_params
    $error("mfa_symbol_streamer: inconsistent WORD_LEN/NSYM_LEN/CNT_LEN");
  end

  logic [EW-1:0]       r_mem [DEPTH];
  logic [FIFO_AW:0]    r_wptr;
  logic [FIFO_AW:0]    r_rptr;
  logic                r_in_ready;
  state_t              r_state;
  logic [WORD_LEN-1:0] r_word;
  logic [NSYM_LEN-1:0] r_rem;
  logic                r_last;
  logic [1:0]          r_symbol;
  logic                r_sym_valid;
  logic                r_bc;
  logic                r_seq_done;

  logic [EW-1:0]       w_head;
  logic [WORD_LEN-1:0] w_head_data;
  logic                w_head_last;
  logic [NSYM_LEN-1:0] w_head_nsym;
  logic [NSYM_LEN-1:0] w_load_rem;
  logic                w_empty;
  logic                w_push;
  logic                w_emit;
  logic                w_done;
  logic                w_load;
  logic [FIFO_AW:0]    w_occ_nxt;

  // A new word may load when the shifter drains this cycle, but never past the last word of a sequence.
  always_comb begin
    w_head = r_mem[r_rptr[FIFO_AW-1:0]];
    {w_head_data, w_head_last, w_head_nsym} = w_head;
    w_empty = r_wptr == r_rptr;
    w_push = in_valid & r_in_ready;
    w_emit = (r_state == STREAM) & (r_rem != '0);
    w_done = (r_state == STREAM) & (r_rem == '0) & r_last;
    w_load = ~hold & ~w_empty & ((r_state == IDLE) | ((r_state == STREAM) & ~r_last & (r_rem[NSYM_LEN-1:1] == '0)));
    w_load_rem = (w_head_last && w_head_nsym != '0) ? w_head_nsym : FULL_REM;
    w_occ_nxt = r_wptr - r_rptr + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_load};
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= {in_data, in_last, in_nsym};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + {{FIFO_AW{1'b0}}, w_push};
      r_rptr     <= r_rptr + {{FIFO_AW{1'b0}}, w_load};
      r_in_ready <= w_occ_nxt != FULL_OCC;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_rem       <= '0;
      r_last      <= 1'b0;
      r_symbol    <= 2'b00;
      r_sym_valid <= 1'b0;
      r_bc        <= 1'b0;
      r_seq_done  <= 1'b0;
    end else if (!hold) begin
      r_symbol    <= w_emit ? r_word[1:0] : 2'b00;
      r_sym_valid <= w_emit;
      r_word      <= w_load ? w_head_data : w_emit ? r_word >> 2 : r_word;
      r_rem       <= w_load ? w_load_rem : w_emit ? r_rem - 1'b1 : r_rem;
      r_last      <= w_load ? w_head_last : r_last;
      r_bc        <= w_emit ? 1'b1 : w_done ? 1'b0 : r_bc;
      r_seq_done  <= w_done;
      r_state     <= w_done ? DONE : (r_state == DONE) ? IDLE : (w_load && r_state == IDLE) ? STREAM : r_state;
    end
  end

`ifdef SYM_COUNT_EN
  logic [CNT_LEN-1:0] r_cnt;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_cnt <= '0;
    else if (w_load && r_state == IDLE) r_cnt <= '0;
    else if (r_sym_valid && !hold && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign sym_count = r_cnt;
`endif

  assign in_ready  = r_in_ready;
  assign symbol    = r_symbol;
  assign sym_valid = r_sym_valid;
  assign BC_mode   = r_bc;
  assign seq_done  = r_seq_done;
endmodule

// File: doc/mfa_symbol_streamer.md
# mfa_symbol_streamer

Upstream feeder for the MFA matching core. Accepts packed sequence words over a valid/ready handshake and buffers them in a small FIFO. Serializes each word into 2-bit symbols, LSB pair first, one per clock. Drives the core's `symbol` and `BC_mode` inputs and pulses `seq_done` after the last symbol of a sequence.

## Interface
- `WORD_LEN`, 32: input word width. Must be even. Holds `WORD_LEN/2` symbols.
- `NSYM_LEN`, 5: width of `in_nsym`. Must satisfy 2^(NSYM_LEN-1) = `WORD_LEN/2`.
- `FIFO_AW`, 2: FIFO address width. Depth is 2^FIFO_AW words.
- `CNT_LEN`, 12: width of the symbol counter.

- `CLK` input 1: clock. All state changes on the rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `in_data` input WORD_LEN: packed symbols. Symbol k is `in_data[2k+1:2k]`.
- `in_nsym` input NSYM_LEN: number of valid symbols in this word. Only meaningful with `in_last`. 0 means full word.
- `in_last` input 1: this word ends the sequence.
- `in_valid` input 1: word present.
- `in_ready` output 1: FIFO can accept a word. Registered.
- `hold` input 1: downstream stall. Freezes symbol output.
- `symbol` output 2: current symbol, registered. Goes to the core's `symbol` input.
- `sym_valid` output 1: `symbol` carries real data this cycle.
- `BC_mode` output 1: high from the first emitted symbol through the last symbol of the sequence.
- `seq_done` output 1: one-cycle pulse, the cycle after the last symbol is presented.
- `sym_count` output CNT_LEN: symbols emitted in the current sequence. Present only with `SYM_COUNT_EN`.

## Operation
- **FIFO**
  - Each entry holds {data, last, nsym}.
  - A push occurs on `in_valid & in_ready`.
  - `in_ready` = registered "not full". When the FIFO is full it stays 0 for that cycle even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: occupancy is unchanged.
  - Pointers are FIFO_AW+1 bits and wrap naturally.
- **Shifter**
  - Holds the current word and `rem`, the number of remaining symbols.
  - Loads from the FIFO head (pop) when `rem` is 0 or becomes 0 this cycle and `hold` is 0.
  - On load, `rem` = `WORD_LEN/2`. If last with `in_nsym` ≠ 0, `rem` = `in_nsym`.
  - Each non-held cycle with `rem` > 0: `symbol` ← word[1:0], word shifts right by 2, `rem` decrements.
- **FSM states**
  - IDLE: `BC_mode`=0. Goes to STREAM on the first load.
  - STREAM: emits symbols. After presenting the final symbol of a last word, goes to DONE.
  - DONE: `seq_done`=1, `BC_mode`=0. Returns to IDLE after one cycle. A FIFO head from the next sequence may load in the following IDLE cycle.
- **Underrun:** in STREAM with the shifter empty and the FIFO empty, `sym_valid`=0 and `symbol`=2'b00. `BC_mode` stays 1.
- **Hold:** `symbol`, `sym_valid`, `rem`, the shifter and the FSM freeze. The FIFO still accepts pushes. If `hold` asserts in the final-symbol cycle, the transition to DONE is deferred until `hold` drops.
- **Reset (any time, including mid-sequence):**
  - FIFO is emptied.
  - `rem`=0, FSM=IDLE.
  - Outputs: `symbol`=0, `sym_valid`=0, `BC_mode`=0, `seq_done`=0, `in_ready`=0.
  - `in_ready` rises to 1 on the first clock edge after reset release.

## Timing
- **Push to first symbol:** a word pushed at edge t and reaching an empty FIFO/shifter is loaded at edge t+1. Its first symbol is valid after edge t+2.
- **Throughput:** 1 symbol/cycle sustained, with no bubble between words when the next word is already in the FIFO.
- **Sequence end:** last symbol presented in cycle n → `seq_done` high in cycle n+1 → IDLE in cycle n+2.
- **`in_ready`** reflects the occupancy as of the previous edge.

## Configuration
- `SYM_COUNT_EN` defined:
  - `sym_count` port exists.
  - Cleared on entering STREAM.
  - Increments on each `sym_valid` & ~`hold` cycle.
  - Saturates at 2^CNT_LEN−1.
  - Holds its value through DONE and IDLE.
- `SYM_COUNT_EN` not defined: the port and the counter logic are absent. Everything else is identical.

## Test plan
- **Single word:** push 32'h000000E4, `in_last`=1, `in_nsym`=4 → `symbol` 0,1,2,3 on 4 consecutive cycles starting at t+2. `seq_done` 1 cycle after symbol 3. `sym_count`=4.
- **Back-to-back words:** push 3 full words then a last word with `in_nsym`=0 → 64 contiguous valid symbols, no bubble, LSB-first order. `BC_mode` high for exactly 64 cycles.
- **FIFO full:** with `hold`=1, push 5 words at depth 4 → `in_ready`=0 after the 4th push and the 5th word is not accepted. Release `hold` → `in_ready` returns to 1 one cycle after the first pop.
- **Underrun:** a 10-cycle gap between non-last words → `sym_valid`=0 and `symbol`=0 during the gap. `BC_mode` stays 1. Streaming resumes 2 cycles after the next push.
- **Hold on the final symbol:** 3 cycles of `hold` on the last symbol → `seq_done` is delayed 3 cycles and `symbol` is stable throughout.
- **Reset mid-sequence:** `RST` low mid-sequence → all outputs 0 immediately (asynchronous). A new sequence after release streams correctly from its first symbol.
